// File: rtl/jogo_memoria_pkg.sv
// Shared types and constants for the memory game: state codes, default
// parameter values and the one-hot pattern of the fixed sequence.
package jogo_memoria_pkg;

    localparam int unsigned N_BOTOES_DEF     = 4;
    localparam int unsigned PROFUNDIDADE_DEF = 16;
    localparam int unsigned T_MOSTRA_DEF     = 1000;
    localparam int unsigned T_TIMEOUT_DEF    = 5000;

    // Codes are fixed so db_estado is stable across builds.
    typedef enum logic [4:0] {
        INICIAL        = 5'd0,
        PREPARACAO     = 5'd1,
        MOSTRA         = 5'd2,
        APAGA          = 5'd3,
        PROXIMA_MOSTRA = 5'd4,
        ESPERA         = 5'd5,
        REGISTRA       = 5'd6,
        COMPARA        = 5'd7,
        PROXIMA_JOGADA = 5'd8,
        GRAVA_NOVA     = 5'd9,
        PROXIMA_RODADA = 5'd10,
        FIM_GANHOU     = 5'd11,
        FIM_PERDEU     = 5'd12,
        FIM_TIMEOUT    = 5'd13
    } estado_t;

    // Element idx of the fixed sequence lights button (idx mod n_botoes).
    function automatic logic [7:0] elemento_fixo(input int unsigned idx,
                                                 input int unsigned n_botoes);
        return 8'(1) << (idx % n_botoes);
    endfunction

endpackage

// File: rtl/jogo_memoria_if.sv
// Player-side bus of the memory game: start/mode/buttons in, LEDs,
// end-of-game flags and debug taps out.
interface jogo_memoria_if #(
    parameter int unsigned N_BOTOES     = 4,
    parameter int unsigned PROFUNDIDADE = 16
);
    localparam int unsigned W_RODADA = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;

    logic                iniciar;
    logic                modo;
    logic [N_BOTOES-1:0] botoes;
    logic [N_BOTOES-1:0] leds;
    logic                pronto;
    logic                ganhou;
    logic                perdeu;
    logic [4:0]          db_estado;
    logic [W_RODADA-1:0] db_rodada;
    logic                db_timeout;

    modport master (
        output iniciar, modo, botoes,
        input  leds, pronto, ganhou, perdeu, db_estado, db_rodada, db_timeout
    );

    modport slave (
        input  iniciar, modo, botoes,
        output leds, pronto, ganhou, perdeu, db_estado, db_rodada, db_timeout
    );

endinterface

// File: rtl/jogo_memoria_param_contador_m.sv
// Modulo-M counter with synchronous clear (priority over enable) and a
// terminal-count flag; used for timers and round/play indices.
module contador_m #(
    parameter  int unsigned M = 4,
    localparam int unsigned W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         fim
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == W'(M - 1)) ? '0 : q + 1'b1;
        end
    end

    assign fim = (q == W'(M - 1));

endmodule

// File: rtl/jogo_memoria_param.sv
// Parameterised memory game (fixed or player-appended sequence).
// Define JOGO_MEMORIA_TIMEOUT_EN to build the per-play timeout.
module jogo_memoria_param
    import jogo_memoria_pkg::*;
#(
    parameter int unsigned N_BOTOES     = N_BOTOES_DEF,
    parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_DEF,
    parameter int unsigned T_MOSTRA     = T_MOSTRA_DEF,
    parameter int unsigned T_TIMEOUT    = T_TIMEOUT_DEF
) (
    input logic           clock,
    input logic           reset,
    jogo_memoria_if.slave bus
);

    localparam int unsigned W_R = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int unsigned W_M = (T_MOSTRA > 1) ? $clog2(T_MOSTRA) : 1;

    estado_t estado, proximo;

    logic                modo_r;
    logic                primeira;
    logic [N_BOTOES-1:0] botoes_ant;
    logic [N_BOTOES-1:0] jogada_val;
    logic [N_BOTOES-1:0] elemento;
    logic [N_BOTOES-1:0] leds_c;
    logic [N_BOTOES-1:0] memoria [PROFUNDIDADE];
    logic [W_R-1:0]      end_grava;
    logic                grava;
    logic                jogada_nova;

    logic           tmr_clr, tmr_en, tmr_fim;
    logic           tmo_clr, tmo_en, tmo_fim;
    logic           rod_clr, rod_en, rod_fim_unused;
    logic           jog_clr, jog_en, jog_fim_unused;
    logic [W_R-1:0] rod_q, jog_q;
    logic [W_M-1:0] tmr_q_unused;

    // ---------------------------------------------------------------
    // Counters: display timer, round index, play/display index
    // ---------------------------------------------------------------
    contador_m #(.M(T_MOSTRA)) u_tmr (
        .clock (clock), .reset (reset), .clr (tmr_clr), .en (tmr_en),
        .q (tmr_q_unused), .fim (tmr_fim)
    );

    contador_m #(.M(PROFUNDIDADE)) u_rodada (
        .clock (clock), .reset (reset), .clr (rod_clr), .en (rod_en),
        .q (rod_q), .fim (rod_fim_unused)
    );

    contador_m #(.M(PROFUNDIDADE)) u_jogada (
        .clock (clock), .reset (reset), .clr (jog_clr), .en (jog_en),
        .q (jog_q), .fim (jog_fim_unused)
    );

`ifdef JOGO_MEMORIA_TIMEOUT_EN
    logic [$clog2(T_TIMEOUT)-1:0] tmo_q_unused;

    contador_m #(.M(T_TIMEOUT)) u_timeout (
        .clock (clock), .reset (reset), .clr (tmo_clr), .en (tmo_en),
        .q (tmo_q_unused), .fim (tmo_fim)
    );

    assign bus.db_timeout = (estado == FIM_TIMEOUT);
`else
    logic unused_tmo;

    assign tmo_fim        = 1'b0;
    assign unused_tmo     = tmo_clr ^ tmo_en ^ (T_TIMEOUT != 0);
    assign bus.db_timeout = 1'b0;
`endif

    // A play is the first cycle the buttons leave all-zero.
    assign jogada_nova = (bus.botoes != '0) && (botoes_ant == '0);

    // Fixed mode derives elements arithmetically; append mode reads storage.
    always_comb begin
        if (modo_r) begin
            elemento = memoria[jog_q];
        end else begin
            elemento = N_BOTOES'(elemento_fixo(32'(jog_q), N_BOTOES));
        end
    end

    // ---------------------------------------------------------------
    // State register and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botoes_ant <= '0;
            jogada_val <= '0;
            modo_r     <= 1'b0;
            primeira   <= 1'b0;
        end else begin
            botoes_ant <= bus.botoes;
            if (estado == ESPERA && jogada_nova) begin
                jogada_val <= bus.botoes;
            end
            if (estado == PREPARACAO) begin
                modo_r   <= bus.modo;
                primeira <= 1'b1;
            end else if (grava) begin
                primeira <= 1'b0;
            end
        end
    end

    // NOTE: the sequence array has no reset; its contents are always
    // written before being read, so a reset would only cost logic.
    always_ff @(posedge clock) begin
        if (grava) begin
            memoria[end_grava] <= bus.botoes;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        proximo   = estado;
        leds_c    = '0;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        rod_clr   = 1'b0;
        rod_en    = 1'b0;
        jog_clr   = 1'b0;
        jog_en    = 1'b0;
        grava     = 1'b0;
        end_grava = primeira ? '0 : rod_q + 1'b1;

        case (estado)
            INICIAL: begin
                if (bus.iniciar) proximo = PREPARACAO;
            end

            PREPARACAO: begin
                rod_clr = 1'b1;
                jog_clr = 1'b1;
                tmr_clr = 1'b1;
                tmo_clr = 1'b1;
                proximo = bus.modo ? GRAVA_NOVA : MOSTRA;
            end

            MOSTRA: begin
                leds_c = elemento;
                tmr_en = 1'b1;
                if (tmr_fim) begin
                    tmr_clr = 1'b1;
                    proximo = APAGA;
                end
            end

            APAGA: begin
                tmr_en = 1'b1;
                if (tmr_fim) begin
                    tmr_clr = 1'b1;
                    if (jog_q == rod_q) begin
                        jog_clr = 1'b1;
                        tmo_clr = 1'b1;
                        proximo = ESPERA;
                    end else begin
                        proximo = PROXIMA_MOSTRA;
                    end
                end
            end

            PROXIMA_MOSTRA: begin
                jog_en  = 1'b1;
                proximo = MOSTRA;
            end

            ESPERA: begin
                leds_c = bus.botoes;
                tmo_en = 1'b1;
                // A play in the expiry cycle still counts.
                if (jogada_nova) begin
                    tmo_clr = 1'b1;
                    proximo = REGISTRA;
                end else if (tmo_fim) begin
                    proximo = FIM_TIMEOUT;
                end
            end

            REGISTRA: begin
                proximo = COMPARA;
            end

            COMPARA: begin
                if (!($onehot(jogada_val) && jogada_val == elemento)) begin
                    proximo = FIM_PERDEU;
                end else if (jog_q != rod_q) begin
                    proximo = PROXIMA_JOGADA;
                end else if (rod_q == W_R'(PROFUNDIDADE - 1)) begin
                    proximo = FIM_GANHOU;
                end else if (modo_r) begin
                    tmo_clr = 1'b1;
                    proximo = GRAVA_NOVA;
                end else begin
                    proximo = PROXIMA_RODADA;
                end
            end

            PROXIMA_JOGADA: begin
                jog_en  = 1'b1;
                tmo_clr = 1'b1;
                proximo = ESPERA;
            end

            GRAVA_NOVA: begin
                leds_c = bus.botoes;
                tmo_en = 1'b1;
                if (jogada_nova) begin
                    tmo_clr = 1'b1;
                    if ($onehot(bus.botoes)) begin
                        grava = 1'b1;
                        // The opening element is shown at once in round 0.
                        if (primeira) begin
                            jog_clr = 1'b1;
                            tmr_clr = 1'b1;
                            proximo = MOSTRA;
                        end else begin
                            proximo = PROXIMA_RODADA;
                        end
                    end else begin
                        proximo = FIM_PERDEU;
                    end
                end else if (tmo_fim) begin
                    proximo = FIM_TIMEOUT;
                end
            end

            PROXIMA_RODADA: begin
                rod_en  = 1'b1;
                jog_clr = 1'b1;
                tmr_clr = 1'b1;
                proximo = MOSTRA;
            end

            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                if (bus.iniciar) proximo = PREPARACAO;
            end

            default: proximo = INICIAL;
        endcase
    end

    // ---------------------------------------------------------------
    // Outputs (state-decoded, except the button echo in leds)
    // ---------------------------------------------------------------
    assign bus.leds      = leds_c;
    assign bus.pronto    = (estado == FIM_GANHOU) || (estado == FIM_PERDEU) ||
                           (estado == FIM_TIMEOUT);
    assign bus.ganhou    = (estado == FIM_GANHOU);
    assign bus.perdeu    = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
    assign bus.db_estado = estado;
    assign bus.db_rodada = rod_q;

endmodule
